// File: rtl/piso_shift_reg.sv
// -----------------------------------------------------------------------------
// piso_shift_reg
//
// Parallel-in / serial-out shift register with a load handshake. A W-bit word
// is accepted when load & ready at a rising edge and is then presented one bit
// per clock on sout, qualified by sval. A new word may be accepted in the
// cycle that carries the last bit of the current word, so back-to-back words
// stream without an idle gap. It feeds the serial input of a bit-pattern
// detector, which uses sval to tell data cycles from idle ones.
//
// Parameters
//   W          word width in bits (W >= 2)
//   MSB_FIRST  1: bit W-1 leaves first; 0: bit 0 leaves first
//
// Ports
//   clk    in   sole clock, rising edge
//   r      in   asynchronous active-low reset
//   load   in   request to accept d (qualified by ready)
//   d      in   W-bit parallel word, sampled only on an accepted load
//   ready  out  combinational, from state only: a load this cycle is accepted
//   sout   out  registered serial data bit (0 whenever sval is 0)
//   sval   out  registered, sout carries a valid data bit
//   busy   out  registered, a word is being shifted out
//   done   out  registered, one-cycle pulse after the last bit of a word
// -----------------------------------------------------------------------------
module piso_shift_reg #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         r,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         ready,
    output logic         sout,
    output logic         sval,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    // Bit of a word that leaves first in the configured order.
    function automatic logic first_bit(input logic [W-1:0] w);
        if (MSB_FIRST) begin
            first_bit = w[W-1];
        end else begin
            first_bit = w[0];
        end
    endfunction

    // Drops the bit that is going out now and moves the next one to the
    // output end. Used both when a word is loaded and on every shift, so
    // first_bit() of the result is always the next bit to present.
    function automatic logic [W-1:0] align_tail(input logic [W-1:0] w);
        if (MSB_FIRST) begin
            align_tail = {w[W-2:0], 1'b0};
        end else begin
            align_tail = {1'b0, w[W-1:1]};
        end
    endfunction

    logic [0:0]    state_r;
    logic [W-1:0]  sreg_r;
    logic [CW-1:0] cnt_r;
    logic          sout_r;
    logic          sval_r;
    logic          busy_r;
    logic          done_r;

    logic [0:0]    state_s;
    logic [W-1:0]  sreg_s;
    logic [CW-1:0] cnt_s;
    logic          sout_s;
    logic          sval_s;
    logic          busy_s;
    logic          done_s;

    logic          last_s;
    logic          ready_s;
    logic          accept_s;

    // cnt_r == 0 means the bit now on sout is the last one of the word.
    assign last_s   = (cnt_r == CNT_ZERO);
    assign accept_s = load & ready_s;

    // Ready decode: depends on state only, never on load, so no loop exists.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_IDLE:  ready_s = 1'b1;
            ST_SHIFT: ready_s = last_s;
            default:  ready_s = 1'b0;
        endcase
    end

    // Next-state and next-output computation for the shifter FSM.
    always_comb begin
        state_s = state_r;
        sreg_s  = sreg_r;
        cnt_s   = cnt_r;
        sout_s  = sout_r;
        sval_s  = sval_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_SHIFT;
                    sout_s  = first_bit(d);
                    sreg_s  = align_tail(d);
                    cnt_s   = CNT_LAST;
                    sval_s  = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    sout_s  = 1'b0;
                    sreg_s  = '0;
                    cnt_s   = CNT_ZERO;
                    sval_s  = 1'b0;
                    busy_s  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (!last_s) begin
                    // Mid-word: present the next bit, load is not accepted here.
                    state_s = ST_SHIFT;
                    sout_s  = first_bit(sreg_r);
                    sreg_s  = align_tail(sreg_r);
                    cnt_s   = cnt_r - CNT_ONE;
                    sval_s  = 1'b1;
                    busy_s  = 1'b1;
                end else if (accept_s) begin
                    // Back-to-back: the old word completes and the new word's
                    // first bit follows with no gap.
                    state_s = ST_SHIFT;
                    sout_s  = first_bit(d);
                    sreg_s  = align_tail(d);
                    cnt_s   = CNT_LAST;
                    sval_s  = 1'b1;
                    busy_s  = 1'b1;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    sout_s  = 1'b0;
                    sreg_s  = '0;
                    cnt_s   = CNT_ZERO;
                    sval_s  = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                sout_s  = 1'b0;
                sreg_s  = '0;
                cnt_s   = CNT_ZERO;
                sval_s  = 1'b0;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything and drops any
    // partial word without issuing done.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_r <= ST_IDLE;
            sreg_r  <= '0;
            cnt_r   <= CNT_ZERO;
            sout_r  <= 1'b0;
            sval_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sreg_r  <= sreg_s;
            cnt_r   <= cnt_s;
            sout_r  <= sout_s;
            sval_r  <= sval_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign ready = ready_s;
    assign sout  = sout_r;
    assign sval  = sval_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_piso_shift_reg.sv
// -----------------------------------------------------------------------------
// Bench for piso_shift_reg. Three instances run side by side:
//   u0: W=8, MSB first    u1: W=8, LSB first    u2: W=2, MSB first
// A queue-based reference model per instance predicts every output each cycle:
// an accepted word pushes its bits in send order onto a queue and each clock
// pops one bit onto sout. A vector table and hand-written sequences add
// explicit expectations for the documented corner cases.
// -----------------------------------------------------------------------------
module tb_piso_shift_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r;
    logic [2:0] load;
    logic [7:0] dv [3];
    logic [7:0] d0, d1;
    logic [1:0] d2;
    logic [2:0] rdy, so, sv, bz, dn;

    assign d0 = dv[0];
    assign d1 = dv[1];
    assign d2 = dv[2][1:0];

    piso_shift_reg #(.W(8), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .r(r), .load(load[0]), .d(d0),
        .ready(rdy[0]), .sout(so[0]), .sval(sv[0]), .busy(bz[0]), .done(dn[0]));
    piso_shift_reg #(.W(8), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .r(r), .load(load[1]), .d(d1),
        .ready(rdy[1]), .sout(so[1]), .sval(sv[1]), .busy(bz[1]), .done(dn[1]));
    piso_shift_reg #(.W(2), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .r(r), .load(load[2]), .d(d2),
        .ready(rdy[2]), .sout(so[2]), .sval(sv[2]), .busy(bz[2]), .done(dn[2]));

    int wid [3] = '{8, 8, 2};
    int msb [3] = '{1, 0, 1};

    // Reference model state
    bit m_val  [3];
    bit m_bit  [3];
    bit m_done [3];
    bit pend   [3][$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ready(input int i);
        return (!m_val[i]) || (pend[i].size() == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_val[i]  = 1'b0;
            m_bit[i]  = 1'b0;
            m_done[i] = 1'b0;
            pend[i].delete();
        end
    endtask

    // One rising edge of the model: a word in flight whose last bit is out
    // completes (done); an accepted word queues its bits in send order.
    task automatic model_edge(input int i);
        bit acc;
        int idx;
        acc       = load[i] && m_ready(i);
        m_done[i] = m_val[i] && (pend[i].size() == 0);
        if (acc) begin
            for (int k = 0; k < wid[i]; k++) begin
                idx = (msb[i] != 0) ? (wid[i] - 1 - k) : k;
                pend[i].push_back(dv[i][idx]);
            end
        end
        if (pend[i].size() > 0) begin
            m_bit[i] = pend[i].pop_front();
            m_val[i] = 1'b1;
        end else begin
            m_bit[i] = 1'b0;
            m_val[i] = 1'b0;
        end
    endtask

    task automatic chk_outputs();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sout[u%0d]", i), so[i], m_bit[i]);
            chk($sformatf("sval[u%0d]", i), sv[i], m_val[i]);
            chk($sformatf("busy[u%0d]", i), bz[i], m_val[i]);
            chk($sformatf("done[u%0d]", i), dn[i], m_done[i]);
        end
    endtask

    // Called at a falling edge with inputs already set; checks ready, takes
    // one rising edge, then checks outputs at the next falling edge.
    task automatic step();
        for (int i = 0; i < 3; i++) chk($sformatf("ready[u%0d]", i), rdy[i], m_ready(i));
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i);
        @(negedge clk);
        chk_outputs();
    endtask

    task automatic chk_all_clear(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s sout[u%0d]", tag, i), so[i], 1'b0);
            chk($sformatf("%s sval[u%0d]", tag, i), sv[i], 1'b0);
            chk($sformatf("%s busy[u%0d]", tag, i), bz[i], 1'b0);
            chk($sformatf("%s done[u%0d]", tag, i), dn[i], 1'b0);
            chk($sformatf("%s ready[u%0d]", tag, i), rdy[i], 1'b1);
        end
    endtask

    // Load one word into instance i and gather the valid bits it emits.
    task automatic send_and_collect(input int i, input logic [7:0] val,
                                    output logic [15:0] col, output int nb);
        load[i] = 1'b1;
        dv[i]   = val;
        step();
        load[i] = 1'b0;
        col = 16'h0000;
        nb  = 0;
        for (int k = 0; k < 12; k++) begin
            if (sv[i]) begin
                col = {col[14:0], so[i]};
                nb++;
            end
            step();
        end
    endtask

    typedef struct {
        logic       ld;
        logic [7:0] dd;
        logic       e_sout;
        logic       e_sval;
        logic       e_busy;
        logic       e_done;
        logic       e_ready;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] col;
        logic [15:0] dmask;
        int          nb;
        int          bdrop;

        // Single 8'hA5 word on u0 (MSB first), sampled after each edge.
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        r    = 1'b0;
        load = 3'b000;
        for (int i = 0; i < 3; i++) dv[i] = 8'h00;
        model_reset();

        // Reset held while the clock runs.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk_all_clear("reset");
        end
        r = 1'b1;

        // Table-driven single word, first accept right after reset release.
        for (int k = 0; k < 10; k++) begin
            load[0] = tbl[k].ld;
            dv[0]   = tbl[k].dd;
            step();
            chk($sformatf("tbl%0d sout", k),  so[0],  tbl[k].e_sout);
            chk($sformatf("tbl%0d sval", k),  sv[0],  tbl[k].e_sval);
            chk($sformatf("tbl%0d busy", k),  bz[0],  tbl[k].e_busy);
            chk($sformatf("tbl%0d done", k),  dn[0],  tbl[k].e_done);
            chk($sformatf("tbl%0d ready", k), rdy[0], tbl[k].e_ready);
        end

        // LSB first on u1: A5 is bit-palindromic; 01 sends 1 then seven 0s.
        send_and_collect(1, 8'hA5, col, nb);
        chk("lsb_a5 bits", col, 16'h00A5);
        chk("lsb_a5 count", nb, 8);
        send_and_collect(1, 8'h01, col, nb);
        chk("lsb_01 bits", col, 16'h0080);
        chk("lsb_01 count", nb, 8);

        // Back-to-back F0 then 0F on u0: load held high, taken at cnt==0.
        load[0] = 1'b1;
        dv[0]   = 8'hF0;
        step();
        dv[0] = 8'h0F;
        col   = 16'h0000;
        dmask = 16'h0000;
        nb    = 0;
        bdrop = 0;
        for (int k = 0; k < 16; k++) begin
            if (sv[0]) begin
                col = {col[14:0], so[0]};
                nb++;
            end
            if (!bz[0]) bdrop++;
            if (dn[0]) dmask[k] = 1'b1;
            if (k == 8) load[0] = 1'b0;
            step();
        end
        chk("b2b bits", col, 16'hF00F);
        chk("b2b count", nb, 16);
        chk("b2b busy_gap", bdrop, 0);
        chk("b2b done_mid", dmask, 16'h0100);
        chk("b2b done_end", dn[0], 1'b1);
        chk("b2b sval_end", sv[0], 1'b0);
        step();

        // Ignored loads of FF while an 00 word is mid-flight.
        load[0] = 1'b1;
        dv[0]   = 8'h00;
        step();
        col = 16'h0000;
        nb  = 0;
        for (int k = 0; k < 10; k++) begin
            if (sv[0]) begin
                col = {col[14:0], so[0]};
                nb++;
            end
            load[0] = (k >= 1 && k <= 5) ? 1'b1 : 1'b0;
            dv[0]   = (k >= 1 && k <= 5) ? 8'hFF : 8'h00;
            step();
        end
        chk("ignore bits", col, 16'h0000);
        chk("ignore count", nb, 8);

        // W=2 on u2: d=2'b10 gives 1,0, ready high in the second bit cycle.
        load[2] = 1'b1;
        dv[2]   = 8'h02;
        step();
        chk("w2 bit0", so[2], 1'b1);
        chk("w2 ready0", rdy[2], 1'b0);
        load[2] = 1'b0;
        step();
        chk("w2 bit1", so[2], 1'b0);
        chk("w2 sval1", sv[2], 1'b1);
        chk("w2 ready1", rdy[2], 1'b1);
        step();
        chk("w2 done", dn[2], 1'b1);
        chk("w2 idle", sv[2], 1'b0);
        step();
        chk("w2 done_clear", dn[2], 1'b0);

        // Asynchronous reset in the middle of a word on u0.
        load[0] = 1'b1;
        dv[0]   = 8'hFF;
        step();
        load[0] = 1'b0;
        step();
        step();
        #2 r = 1'b0;
        #1 chk_all_clear("async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk_all_clear("async_hold");
        r = 1'b1;
        for (int k = 0; k < 3; k++) step();

        // Randomized traffic on all three instances against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                load[i] = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
                dv[i]   = 8'($urandom);
            end
            step();
        end
        load = 3'b000;
        for (int k = 0; k < 10; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/piso_shift_reg.md
# piso_shift_reg

Parameterized parallel-in/serial-out shift register with a load handshake. It accepts a W-bit word and emits it one bit per clock, framed by a valid strobe. It sits directly upstream of the serial bit-pattern detector FSM: `sout` drives the detector's serial input `i`, and `sval` qualifies which cycles carry real data. Back-to-back words stream with no idle gap.

## Interface
- `W`, default 8: word width in bits; legal range W ≥ 2.
- `MSB_FIRST`, default 1: 1 shifts bit W-1 first; 0 shifts bit 0 first.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `r`  input  1  reset; asynchronous, active-low (r=0 forces reset immediately, independent of clk).
- `load`  input  1  request to accept `d`; qualified by `ready`.
- `d`  input  W  parallel word; sampled only on an accepted load.
- `ready`  output  1  combinational; high when a load this cycle will be accepted.
- `sout`  output  1  registered serial data bit.
- `sval`  output  1  registered; high when `sout` carries a valid data bit.
- `busy`  output  1  registered; high while a word is being shifted out.
- `done`  output  1  registered; one-cycle pulse after the last bit of each word.

## Operation
- Internal state: shift register `sreg[W-1:0]`, bit counter `cnt` of width clog2(W), FSM with two states, IDLE and SHIFT.
- Reset (r=0): IDLE, `sreg`=0, `cnt`=0, `sout`=0, `sval`=0, `busy`=0, `done`=0. `ready`=1 once r=1.
- `ready` = (state==IDLE) | (state==SHIFT & cnt==0). `cnt`==0 marks the last bit currently on `sout`.
- Accept = load & ready at a rising edge. On accept:
  - the first bit of `d` goes to `sout` (d[W-1] if MSB_FIRST, else d[0]);
  - the remaining bits load into `sreg`;
  - `cnt` = W-1, `sval` = 1, `busy` = 1, state = SHIFT.
- SHIFT, cnt>0: each edge presents the next bit in order, cnt decrements, `sval` stays 1.
- SHIFT, cnt==0, no accept: next edge goes to IDLE with `sval`=0, `busy`=0, `sout`=0, `done`=1.
- SHIFT, cnt==0, accept (back-to-back): next edge presents the first bit of the new word, with `sval`=1, `busy`=1, `done`=1. The stream has no gap.
- `done` is high for exactly one cycle per completed word, then returns to 0.
- Load while ready=0 is ignored; `d` changes while shifting have no effect.
- IDLE with no load: all outputs hold reset values, except `done` clears after its pulse.
- `sout` is 0 whenever `sval`=0.

## Timing
- Latency: accept at edge N gives bit 0 of the word on `sout` during cycle N..N+1. The last bit is present after edge N+W-1.
- Without reload: `done`=1 and `sval`=0 after edge N+W.
- Throughput: one bit per clock. Continuous streaming requires load asserted in every cnt==0 cycle.
- Reset mid-word: outputs clear asynchronously. The partial word is discarded and no `done` is issued.
- Reset release: the first accept can occur at the first rising edge with r=1.
- `ready` has a combinational path from state only, not from `load`. There is no loop.

## Test plan
- Reset with W=8: hold r=0 while toggling clk → `sout`=0, `sval`=0, `busy`=0, `done`=0, `ready`=1. Assert r=0 mid-word → all outputs clear before the next edge.
- Single word: W=8, MSB_FIRST=1, load=1 with d=8'hA5 for one cycle → `sout` = 1,0,1,0,0,1,0,1 on 8 consecutive `sval`=1 cycles. On the 9th cycle, `sval`=0 and `done`=1 for one cycle.
- LSB-first: MSB_FIRST=0, d=8'hA5 → `sout` = 1,0,1,0,0,1,0,1 (A5 is bit-palindromic). Repeat with d=8'h01 → 1 then seven 0s.
- Back-to-back: load 8'hF0, then hold load with d=8'h0F during the cnt==0 cycle → 16 contiguous `sval`=1 bits 1111000000001111. `done` pulses after bit 8 and after bit 16; `busy` never drops between words.
- Ignored load: assert load with d=8'hFF at cycles 2 through 6 of an 8'h00 word → output stays eight 0s, and there is no accept until `ready`=1.
- Width sweep: W=2, d=2'b10 → `sout`=1,0, then `done`. `cnt` wraps correctly and `ready` is high in the second bit cycle.
